axi_write_ctrl: RTL and testbench
=================================

# axi_write_ctrl

- Write-channel controller for master M1 in the AXI interconnect.
- Accepts one AW request at a time and decodes the target slave (S0, S1, or unmapped).
- Forwards the address to that slave, steers WVALID/WREADY to the selected slave only, counts beats, then routes the B response back to M1.
- Drives `write_slave` to the W data mux (WDATA/WSTRB/WLAST fan-out) and acts as default slave (DECERR) for unmapped addresses.

## Interface

Parameters:
- MASTER_TAG, 4'd1, upper ID nibble prepended to AWID on the slave side.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - ACLK  in  1  clock
  - ARESET  in  1  async reset
- M1 write address:
  - AWID_M1  in  4  write ID
  - AWADDR_M1  in  32  write address
  - AWLEN_M1  in  4  burst length minus 1
  - AWSIZE_M1  in  3  beat size
  - AWBURST_M1  in  2  burst type
  - AWVALID_M1  in  1  address valid
  - AWREADY_M1  out  1  address ready
- Per-slave address (x = 0, 1):
  - AWID_Sx  out  8  {MASTER_TAG, AWID}
  - AWADDR_Sx  out  32  address
  - AWLEN_Sx  out  4  burst length
  - AWSIZE_Sx  out  3  beat size
  - AWBURST_Sx  out  2  burst type
  - AWVALID_Sx  out  1  address valid
  - AWREADY_Sx  in  1  address ready
- W handshake:
  - WVALID_M1  in  1  data valid
  - WLAST_M1  in  1  last beat
  - WREADY_M1  out  1  data ready
  - WVALID_Sx  out  1  data valid to slave x
  - WREADY_Sx  in  1  data ready from slave x
- write_slave  out  2  W mux select: 2'b01 = S0, 2'b10 = S1, 2'b00 = none
- Response:
  - BID_Sx  in  8  response ID
  - BRESP_Sx  in  2  response code
  - BVALID_Sx  in  1  response valid
  - BREADY_Sx  out  1  response ready
  - BID_M1  out  4  response ID
  - BRESP_M1  out  2  response code
  - BVALID_M1  out  1  response valid
  - BREADY_M1  in  1  response ready

## Operation

- FSM states: IDLE, ADDR, DATA, RESP.
- Address decode on AWADDR_M1[31:16]:
  - 16'h0000 selects S0.
  - 16'h0001 selects S1.
  - Any other value is unmapped (DEF).
- IDLE:
  - AWREADY_M1 = 1.
  - On an AWVALID_M1 handshake, register the AW fields, the decoded target and a cleared beat counter.
  - Go to ADDR for a mapped target, DATA for DEF.
- ADDR:
  - Drive the registered AW fields.
  - AWVALID is asserted only to the target slave.
  - On AWREADY from the target, go to DATA.
- DATA:
  - write_slave = target.
  - WVALID_target = WVALID_M1; WREADY_M1 = WREADY_target. The other slave sees WVALID = 0.
  - For DEF: WREADY_M1 = 1, beats are discarded, write_slave = 2'b00.
  - The 4-bit counter increments per W handshake.
  - The beat with counter == AWLEN ends the burst; go to RESP.
- RESP, mapped target:
  - BVALID_M1 = BVALID_target; BREADY_target = BREADY_M1.
  - BID_M1 = BID_target[3:0]; BRESP_M1 = BRESP_target.
- RESP, DEF:
  - BVALID_M1 = 1, BRESP_M1 = 2'b11 (DECERR), BID_M1 = registered AWID.
- On a B handshake, return to IDLE.
- Only one outstanding write is allowed; AWREADY_M1 is 0 outside IDLE.
- AW outputs driven to a slave that is not the target are all 0.

## Timing

- Reset values: state IDLE, counter 0, every output 0 except AWREADY_M1.
  - AWREADY_M1 = 1 immediately after reset deassertion, because state is IDLE.
- Reset asserted mid-transaction aborts to IDLE the same cycle.
  - No B response is issued.
  - AWVALID_Sx, WVALID_Sx and BVALID_M1 drop asynchronously.
- AW accepted at cycle T → AWVALID_Sx = 1 at T+1 (registered). It holds until AWREADY_Sx.
- W routing is combinational within DATA. A last-beat handshake at cycle T puts the FSM in RESP at T+1.
- For DEF, BVALID_M1 = 1 on the first RESP cycle and holds until BREADY_M1.
- A B handshake at T returns to IDLE at T+1; the next AW can be accepted at T+1.
- Minimum single-beat mapped write: 4 cycles from AW acceptance to return to IDLE, with zero-wait slaves.

## Configuration

- `AXI_WLAST_CHECK_EN` defined:
  - A WLAST_M1 mismatch sets a sticky error flag. A mismatch is WLAST high before counter == AWLEN, or low at counter == AWLEN.
  - The burst still ends on the counter.
  - In RESP, BRESP_M1 is forced to 2'b10 (SLVERR) when the flag is set, unless the response is DECERR.
  - The flag clears on return to IDLE.
- Not defined:
  - No flag exists and WLAST_M1 is ignored by the controller.
  - The burst ends on the counter only; the slave's BRESP passes unmodified.

## Test plan

- AWADDR 0x0000_0010, AWLEN 0, one beat, zero-wait S0 → AWVALID_S0 at T+1, write_slave 2'b01, WVALID_S1 stays 0, BRESP_M1 = S0's 2'b00, back to IDLE at T+4.
- AWADDR 0x0001_0000, AWLEN 3, four beats with WREADY_S1 toggling → exactly 4 handshakes routed to S1, RESP entered after the 4th, BID_M1 = AWID, AWID_S1 = {4'd1, AWID}.
- AWADDR 0x0002_0000, AWLEN 1 → no AWVALID_Sx, two beats absorbed with WREADY_M1 = 1, BRESP_M1 = 2'b11.
- With `AXI_WLAST_CHECK_EN`: AWLEN 3 to S0, WLAST_M1 high on beat 2 → 4 beats still counted, BRESP_M1 = 2'b10. Without the macro → BRESP_M1 = 2'b00.
- AWREADY_S0 delayed 3 cycles → AWVALID_S0 and AW fields stable for all 3 cycles, AWREADY_M1 = 0 throughout.
- ARESET pulsed during DATA beat 2 of 4 → all outputs 0 at once, AWREADY_M1 = 1 after release, no BVALID_M1, a new write completes normally.

Source files
------------

// File: rtl/axi_write_ctrl_if.sv
// axi_write_ctrl_if
//   Bundles the M1 write channel (AW/W/B) and the two slave-side write
//   channels (S0, S1) seen by the M1 write controller.
//   modport master : controller view (drives slave-side AW/W valid, B ready
//                    and the M1 ready/response signals)
//   modport slave  : environment view (the M1 master and both slaves)
interface axi_write_ctrl_if;
  // M1 address
  logic [3:0]  AWID_M1;
  logic [31:0] AWADDR_M1;
  logic [3:0]  AWLEN_M1;
  logic [2:0]  AWSIZE_M1;
  logic [1:0]  AWBURST_M1;
  logic        AWVALID_M1;
  logic        AWREADY_M1;
  // S0 / S1 address
  logic [7:0]  AWID_S0,    AWID_S1;
  logic [31:0] AWADDR_S0,  AWADDR_S1;
  logic [3:0]  AWLEN_S0,   AWLEN_S1;
  logic [2:0]  AWSIZE_S0,  AWSIZE_S1;
  logic [1:0]  AWBURST_S0, AWBURST_S1;
  logic        AWVALID_S0, AWVALID_S1;
  logic        AWREADY_S0, AWREADY_S1;
  // W handshake
  logic        WVALID_M1, WLAST_M1, WREADY_M1;
  logic        WVALID_S0, WVALID_S1;
  logic        WREADY_S0, WREADY_S1;
  // B
  logic [7:0]  BID_S0,    BID_S1;
  logic [1:0]  BRESP_S0,  BRESP_S1;
  logic        BVALID_S0, BVALID_S1;
  logic        BREADY_S0, BREADY_S1;
  logic [3:0]  BID_M1;
  logic [1:0]  BRESP_M1;
  logic        BVALID_M1;
  logic        BREADY_M1;

  modport master (
    input  AWID_M1, AWADDR_M1, AWLEN_M1, AWSIZE_M1, AWBURST_M1, AWVALID_M1,
    output AWREADY_M1,
    output AWID_S0, AWADDR_S0, AWLEN_S0, AWSIZE_S0, AWBURST_S0, AWVALID_S0,
    output AWID_S1, AWADDR_S1, AWLEN_S1, AWSIZE_S1, AWBURST_S1, AWVALID_S1,
    input  AWREADY_S0, AWREADY_S1,
    input  WVALID_M1, WLAST_M1,
    output WREADY_M1, WVALID_S0, WVALID_S1,
    input  WREADY_S0, WREADY_S1,
    input  BID_S0, BRESP_S0, BVALID_S0, BID_S1, BRESP_S1, BVALID_S1,
    output BREADY_S0, BREADY_S1,
    output BID_M1, BRESP_M1, BVALID_M1,
    input  BREADY_M1
  );

  modport slave (
    output AWID_M1, AWADDR_M1, AWLEN_M1, AWSIZE_M1, AWBURST_M1, AWVALID_M1,
    input  AWREADY_M1,
    input  AWID_S0, AWADDR_S0, AWLEN_S0, AWSIZE_S0, AWBURST_S0, AWVALID_S0,
    input  AWID_S1, AWADDR_S1, AWLEN_S1, AWSIZE_S1, AWBURST_S1, AWVALID_S1,
    output AWREADY_S0, AWREADY_S1,
    output WVALID_M1, WLAST_M1,
    input  WREADY_M1, WVALID_S0, WVALID_S1,
    output WREADY_S0, WREADY_S1,
    output BID_S0, BRESP_S0, BVALID_S0, BID_S1, BRESP_S1, BVALID_S1,
    input  BREADY_S0, BREADY_S1,
    input  BID_M1, BRESP_M1, BVALID_M1,
    output BREADY_M1
  );
endinterface

// File: rtl/axi_write_ctrl.sv
// axi_write_ctrl
//   Write-channel controller for master M1. Takes one AW at a time, decodes
//   AWADDR[31:16] to S0 (0x0000), S1 (0x0001) or unmapped, forwards AW to the
//   target, steers the W handshake, counts beats and routes B back to M1.
//   Unmapped writes are absorbed locally and answered with DECERR.
// Ports
//   ACLK        clock
//   ARESET      asynchronous active-high reset
//   bus         axi_write_ctrl_if.master (M1, S0, S1 write channels)
//   write_slave W data mux select: 01 = S0, 10 = S1, 00 = none
// Optional feature
//   AXI_WLAST_CHECK_EN : flag WLAST_M1 disagreeing with the beat counter and
//                        turn a mapped response into SLVERR.
module axi_write_ctrl #(
  parameter logic [3:0] MASTER_TAG = 4'd1
) (
  input  logic             ACLK,
  input  logic             ARESET,
  axi_write_ctrl_if.master bus,
  output logic [1:0]       write_slave
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  // Target encoding doubles as the write_slave value; 00 = default slave.
  localparam logic [1:0] TGT_DEF = 2'b00;
  localparam logic [1:0] TGT_S0  = 2'b01;
  localparam logic [1:0] TGT_S1  = 2'b10;

  state_t      state, nxt;
  logic [3:0]  awid_q, awlen_q, cnt_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic [1:0]  awburst_q, tgt_q, dec_tgt;
  logic        sel_s0, sel_s1;
  logic        aw_hs, w_rdy, w_hs, w_last, b_vld, b_hs;

  assign dec_tgt = (bus.AWADDR_M1[31:16] == 16'h0000) ? TGT_S0 :
                   (bus.AWADDR_M1[31:16] == 16'h0001) ? TGT_S1 : TGT_DEF;

  assign sel_s0 = (tgt_q == TGT_S0);
  assign sel_s1 = (tgt_q == TGT_S1);

  // Default slave is always ready for W and always has a B pending.
  assign w_rdy  = sel_s0 ? bus.WREADY_S0 : sel_s1 ? bus.WREADY_S1 : 1'b1;
  assign b_vld  = sel_s0 ? bus.BVALID_S0 : sel_s1 ? bus.BVALID_S1 : 1'b1;
  assign aw_hs  = (state == IDLE) && bus.AWVALID_M1;
  assign w_hs   = (state == DATA) && bus.WVALID_M1 && w_rdy;
  assign w_last = (cnt_q == awlen_q);
  assign b_hs   = (state == RESP) && b_vld && bus.BREADY_M1;

`ifdef AXI_WLAST_CHECK_EN
  logic err_q;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                              err_q <= 1'b0;
    else if (state == IDLE)                  err_q <= 1'b0;
    else if (w_hs && (bus.WLAST_M1 != w_last)) err_q <= 1'b1;
  end
  logic unused_bits;
  assign unused_bits = ^{bus.BID_S0[7:4], bus.BID_S1[7:4]};
`else
  // WLAST is not used: the burst ends on the beat counter alone.
  logic unused_bits;
  assign unused_bits = ^{bus.WLAST_M1, bus.BID_S0[7:4], bus.BID_S1[7:4]};
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      tgt_q     <= TGT_DEF;
      cnt_q     <= '0;
    end else begin
      state <= nxt;
      if (aw_hs) begin
        awid_q    <= bus.AWID_M1;
        awaddr_q  <= bus.AWADDR_M1;
        awlen_q   <= bus.AWLEN_M1;
        awsize_q  <= bus.AWSIZE_M1;
        awburst_q <= bus.AWBURST_M1;
        tgt_q     <= dec_tgt;
        cnt_q     <= '0;
      end else if (w_hs) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    nxt            = state;
    write_slave    = TGT_DEF;
    bus.AWREADY_M1 = 1'b0;
    bus.AWID_S0    = '0; bus.AWADDR_S0 = '0; bus.AWLEN_S0 = '0;
    bus.AWSIZE_S0  = '0; bus.AWBURST_S0 = '0; bus.AWVALID_S0 = 1'b0;
    bus.AWID_S1    = '0; bus.AWADDR_S1 = '0; bus.AWLEN_S1 = '0;
    bus.AWSIZE_S1  = '0; bus.AWBURST_S1 = '0; bus.AWVALID_S1 = 1'b0;
    bus.WREADY_M1  = 1'b0;
    bus.WVALID_S0  = 1'b0;
    bus.WVALID_S1  = 1'b0;
    bus.BREADY_S0  = 1'b0;
    bus.BREADY_S1  = 1'b0;
    bus.BID_M1     = '0;
    bus.BRESP_M1   = '0;
    bus.BVALID_M1  = 1'b0;

    case (state)
      IDLE: begin
        bus.AWREADY_M1 = 1'b1;
        if (bus.AWVALID_M1) nxt = (dec_tgt == TGT_DEF) ? DATA : ADDR;
      end
      ADDR: begin
        if (sel_s0) begin
          bus.AWID_S0    = {MASTER_TAG, awid_q};
          bus.AWADDR_S0  = awaddr_q;
          bus.AWLEN_S0   = awlen_q;
          bus.AWSIZE_S0  = awsize_q;
          bus.AWBURST_S0 = awburst_q;
          bus.AWVALID_S0 = 1'b1;
          if (bus.AWREADY_S0) nxt = DATA;
        end else if (sel_s1) begin
          bus.AWID_S1    = {MASTER_TAG, awid_q};
          bus.AWADDR_S1  = awaddr_q;
          bus.AWLEN_S1   = awlen_q;
          bus.AWSIZE_S1  = awsize_q;
          bus.AWBURST_S1 = awburst_q;
          bus.AWVALID_S1 = 1'b1;
          if (bus.AWREADY_S1) nxt = DATA;
        end else begin
          nxt = DATA;
        end
      end
      DATA: begin
        write_slave   = tgt_q;
        bus.WREADY_M1 = w_rdy;
        bus.WVALID_S0 = sel_s0 && bus.WVALID_M1;
        bus.WVALID_S1 = sel_s1 && bus.WVALID_M1;
        if (w_hs && w_last) nxt = RESP;
      end
      RESP: begin
        bus.BVALID_M1 = b_vld;
        if (sel_s0) begin
          bus.BREADY_S0 = bus.BREADY_M1;
          bus.BID_M1    = bus.BID_S0[3:0];
          bus.BRESP_M1  = bus.BRESP_S0;
        end else if (sel_s1) begin
          bus.BREADY_S1 = bus.BREADY_M1;
          bus.BID_M1    = bus.BID_S1[3:0];
          bus.BRESP_M1  = bus.BRESP_S1;
        end else begin
          bus.BID_M1    = awid_q;
          bus.BRESP_M1  = 2'b11;
        end
`ifdef AXI_WLAST_CHECK_EN
        if (err_q && (sel_s0 || sel_s1)) bus.BRESP_M1 = 2'b10;
`endif
        if (b_hs) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_write_ctrl.sv
// tb_axi_write_ctrl
//   Directed bench for axi_write_ctrl: the bench plays M1 and both slaves.
//   Inputs change 1 time unit after the rising edge; outputs are read one
//   further unit later, well before the next rising edge.
module tb_axi_write_ctrl;
  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic [1:0] write_slave;
  int         n_chk = 0;
  int         n_pass = 0;

  axi_write_ctrl_if bus();

  axi_write_ctrl #(.MASTER_TAG(4'd1)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .write_slave(write_slave)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic clr_inputs();
    bus.AWID_M1 = '0; bus.AWADDR_M1 = '0; bus.AWLEN_M1 = '0; bus.AWSIZE_M1 = '0;
    bus.AWBURST_M1 = '0; bus.AWVALID_M1 = 1'b0;
    bus.AWREADY_S0 = 1'b0; bus.AWREADY_S1 = 1'b0;
    bus.WVALID_M1 = 1'b0; bus.WLAST_M1 = 1'b0;
    bus.WREADY_S0 = 1'b0; bus.WREADY_S1 = 1'b0;
    bus.BID_S0 = '0; bus.BRESP_S0 = '0; bus.BVALID_S0 = 1'b0;
    bus.BID_S1 = '0; bus.BRESP_S1 = '0; bus.BVALID_S1 = 1'b0;
    bus.BREADY_M1 = 1'b0;
  endtask

  // Present one AW, check it is accepted on the next edge, then drop it.
  task automatic aw_req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    bus.AWID_M1 = id; bus.AWADDR_M1 = addr; bus.AWLEN_M1 = len;
    bus.AWSIZE_M1 = 3'd2; bus.AWBURST_M1 = 2'd1; bus.AWVALID_M1 = 1'b1;
    #1 chk("aw_ready_idle", bus.AWREADY_M1, 1);
    tick();
    bus.AWVALID_M1 = 1'b0;
    #1;
  endtask

  // Single-beat write to S0 with aw_wait cycles of AWREADY_S0 back-pressure.
  task automatic single_s0(input logic [3:0] id, input logic [31:0] addr, input int aw_wait);
    aw_req(id, addr, 4'd0);
    for (int i = 0; i < aw_wait; i++) begin
      chk("s0_awvalid_hold", bus.AWVALID_S0, 1);
      chk("s0_awaddr_hold",  bus.AWADDR_S0, addr);
      chk("s0_awsize_hold",  bus.AWSIZE_S0, 3'd2);
      chk("s0_awready_m1_0", bus.AWREADY_M1, 0);
      tick(); #1;
    end
    chk("s0_awvalid",  bus.AWVALID_S0, 1);
    chk("s1_awvalid",  bus.AWVALID_S1, 0);
    chk("s0_awaddr",   bus.AWADDR_S0, addr);
    chk("s0_awid",     bus.AWID_S0, {4'd1, id});
    chk("s1_awaddr_0", bus.AWADDR_S1, 0);
    chk("awready_busy", bus.AWREADY_M1, 0);
    bus.AWREADY_S0 = 1'b1;
    tick();
    bus.AWREADY_S0 = 1'b0;
    bus.WVALID_M1 = 1'b1; bus.WLAST_M1 = 1'b1; bus.WREADY_S0 = 1'b1;
    #1;
    chk("s0_write_slave", write_slave, 2'b01);
    chk("s0_wvalid",      bus.WVALID_S0, 1);
    chk("s1_wvalid_0",    bus.WVALID_S1, 0);
    chk("s0_wready_m1",   bus.WREADY_M1, 1);
    tick();
    bus.WVALID_M1 = 1'b0; bus.WLAST_M1 = 1'b0; bus.WREADY_S0 = 1'b0;
    bus.BVALID_S0 = 1'b1; bus.BID_S0 = {4'd1, id}; bus.BRESP_S0 = 2'b00; bus.BREADY_M1 = 1'b1;
    #1;
    chk("s0_bvalid_m1", bus.BVALID_M1, 1);
    chk("s0_bresp_m1",  bus.BRESP_M1, 2'b00);
    chk("s0_bid_m1",    bus.BID_M1, id);
    chk("s0_bready",    bus.BREADY_S0, 1);
    tick();
    bus.BVALID_S0 = 1'b0; bus.BREADY_M1 = 1'b0;
    #1;
    chk("s0_idle_again", bus.AWREADY_M1, 1);
    chk("s0_bvalid_off", bus.BVALID_M1, 0);
  endtask

  initial begin
    int hs;
    logic tog, s0_seen;
    logic [1:0] exp_resp;
    clr_inputs();
    // Reset state
    tick(); tick();
    chk("rst_awready",  bus.AWREADY_M1, 1);
    chk("rst_awvalid0", bus.AWVALID_S0, 0);
    chk("rst_wslave",   write_slave, 0);
    chk("rst_bvalid",   bus.BVALID_M1, 0);
    ARESET = 1'b0;
    tick();
    chk("post_rst_awready", bus.AWREADY_M1, 1);

    // 1: single beat to S0, zero wait
    single_s0(4'h5, 32'h0000_0010, 0);

    // 2: four beats to S1 with toggling WREADY_S1
    aw_req(4'hA, 32'h0001_0000, 4'd3);
    chk("s1_awvalid",  bus.AWVALID_S1, 1);
    chk("s1_s0_quiet", bus.AWVALID_S0, 0);
    chk("s1_awid",     bus.AWID_S1, 8'h1A);
    chk("s1_awlen",    bus.AWLEN_S1, 4'd3);
    bus.AWREADY_S1 = 1'b1;
    tick();
    bus.AWREADY_S1 = 1'b0;
    hs = 0; tog = 1'b0; s0_seen = 1'b0;
    for (int c = 0; c < 20 && hs < 4; c++) begin
      bus.WREADY_S1 = tog; tog = ~tog;
      bus.WVALID_M1 = 1'b1; bus.WLAST_M1 = (hs == 3);
      #1;
      chk("s1_wready_m1", bus.WREADY_M1, bus.WREADY_S1);
      if (bus.WVALID_S0) s0_seen = 1'b1;
      if (bus.WVALID_S1 && bus.WREADY_S1) hs++;
      tick();
    end
    bus.WVALID_M1 = 1'b0; bus.WLAST_M1 = 1'b0; bus.WREADY_S1 = 1'b0;
    #1;
    chk("s1_beats",      hs, 4);
    chk("s1_s0_wvalid",  s0_seen, 0);
    chk("s1_left_data",  write_slave, 0);
    bus.BVALID_S1 = 1'b1; bus.BID_S1 = 8'h1A; bus.BRESP_S1 = 2'b01; bus.BREADY_M1 = 1'b1;
    #1;
    chk("s1_bvalid_m1", bus.BVALID_M1, 1);
    chk("s1_bid_m1",    bus.BID_M1, 4'hA);
    chk("s1_bresp_m1",  bus.BRESP_M1, 2'b01);
    chk("s1_bready",    bus.BREADY_S1, 1);
    chk("s1_bready_s0", bus.BREADY_S0, 0);
    tick();
    bus.BVALID_S1 = 1'b0; bus.BREADY_M1 = 1'b0;
    #1 chk("s1_idle", bus.AWREADY_M1, 1);

    // 3: unmapped address, two beats absorbed, DECERR
    aw_req(4'h3, 32'h0002_0000, 4'd1);
    chk("def_awvalid0", bus.AWVALID_S0, 0);
    chk("def_awvalid1", bus.AWVALID_S1, 0);
    chk("def_wslave",   write_slave, 0);
    chk("def_wready",   bus.WREADY_M1, 1);
    bus.WVALID_M1 = 1'b1;
    tick();
    bus.WLAST_M1 = 1'b1;
    #1;
    chk("def_wvalid_s0", bus.WVALID_S0, 0);
    chk("def_mid_bvalid", bus.BVALID_M1, 0);
    tick();
    bus.WVALID_M1 = 1'b0; bus.WLAST_M1 = 1'b0;
    #1;
    chk("def_bvalid", bus.BVALID_M1, 1);
    chk("def_bresp",  bus.BRESP_M1, 2'b11);
    chk("def_bid",    bus.BID_M1, 4'h3);
    tick();
    chk("def_bvalid_hold", bus.BVALID_M1, 1);
    bus.BREADY_M1 = 1'b1;
    tick();
    bus.BREADY_M1 = 1'b0;
    #1 chk("def_idle", bus.AWREADY_M1, 1);

    // 4: WLAST on beat 2 of 4; burst still ends on the counter
    aw_req(4'h4, 32'h0000_0100, 4'd3);
    bus.AWREADY_S0 = 1'b1;
    tick();
    bus.AWREADY_S0 = 1'b0;
    bus.WVALID_M1 = 1'b1; bus.WREADY_S0 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.WLAST_M1 = (b == 1);
      #1;
      chk("wl_in_data", write_slave, 2'b01);
      tick();
    end
    bus.WVALID_M1 = 1'b0; bus.WLAST_M1 = 1'b0; bus.WREADY_S0 = 1'b0;
    bus.BVALID_S0 = 1'b1; bus.BID_S0 = 8'h14; bus.BRESP_S0 = 2'b00; bus.BREADY_M1 = 1'b1;
`ifdef AXI_WLAST_CHECK_EN
    exp_resp = 2'b10;
`else
    exp_resp = 2'b00;
`endif
    #1;
    chk("wl_bvalid", bus.BVALID_M1, 1);
    chk("wl_bresp",  bus.BRESP_M1, exp_resp);
    tick();
    bus.BVALID_S0 = 1'b0; bus.BREADY_M1 = 1'b0;

    // 5: AWREADY_S0 held off for 3 cycles
    single_s0(4'h2, 32'h0000_0040, 3);

    // 6: reset during beat 2 of 4, then a clean write
    aw_req(4'h6, 32'h0001_0100, 4'd3);
    bus.AWREADY_S1 = 1'b1;
    tick();
    bus.AWREADY_S1 = 1'b0;
    bus.WVALID_M1 = 1'b1; bus.WREADY_S1 = 1'b1;
    tick();
    ARESET = 1'b1;
    #1;
    chk("ar_wvalid_s1", bus.WVALID_S1, 0);
    chk("ar_wready_m1", bus.WREADY_M1, 0);
    chk("ar_wslave",    write_slave, 0);
    chk("ar_bvalid",    bus.BVALID_M1, 0);
    chk("ar_awvalid",   bus.AWVALID_S1, 0);
    bus.WVALID_M1 = 1'b0; bus.WREADY_S1 = 1'b0;
    #1 ARESET = 1'b0;
    #1;
    chk("ar_awready", bus.AWREADY_M1, 1);
    tick();
    chk("ar_no_b", bus.BVALID_M1, 0);
    single_s0(4'h7, 32'h0000_0020, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute bound in case the DUT stalls the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of sequence, expected finish");
    $fatal(1, "timeout");
  end
endmodule
